// File: rtl/alu_mc_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode map, control FSM encoding and
// opcode-class decode helpers used by both the top level and the iterative core.
package alu_mc_pkg;

   // Base operation set (bit 4 clear)
   localparam logic [4:0] OpAdd    = 5'h01;
   localparam logic [4:0] OpSub    = 5'h02;
   localparam logic [4:0] OpSll    = 5'h03;
   localparam logic [4:0] OpSlt    = 5'h04;
   localparam logic [4:0] OpSltu   = 5'h05;
   localparam logic [4:0] OpSrl    = 5'h06;
   localparam logic [4:0] OpSra    = 5'h07;
   localparam logic [4:0] OpXor    = 5'h08;
   localparam logic [4:0] OpOr     = 5'h09;
   localparam logic [4:0] OpAnd    = 5'h0A;
   localparam logic [4:0] OpLui    = 5'h0B;
   localparam logic [4:0] OpAuipc  = 5'h0C;

   // M-extension set
   localparam logic [4:0] OpMul    = 5'h10;
   localparam logic [4:0] OpMulh   = 5'h11;
   localparam logic [4:0] OpMulhsu = 5'h12;
   localparam logic [4:0] OpMulhu  = 5'h13;
   localparam logic [4:0] OpDiv    = 5'h14;
   localparam logic [4:0] OpDivu   = 5'h15;
   localparam logic [4:0] OpRem    = 5'h16;
   localparam logic [4:0] OpRemu   = 5'h17;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StDone = 2'd3
   } alu_state_e;

   // 0x10..0x17
   function automatic logic is_m_op(input logic [4:0] op);
      return op[4:3] == 2'b10;
   endfunction

   // 0x14..0x17
   function automatic logic is_div_op(input logic [4:0] op);
      return op[4:2] == 3'b101;
   endfunction

   function automatic logic is_rem_op(input logic [4:0] op);
      return (op == OpRem) || (op == OpRemu);
   endfunction

   function automatic logic is_signed_div(input logic [4:0] op);
      return (op == OpDiv) || (op == OpRem);
   endfunction

   // Operand A is two's complement for these opcodes
   function automatic logic op_a_signed(input logic [4:0] op);
      return (op == OpMul) || (op == OpMulh) || (op == OpMulhsu) ||
             (op == OpDiv) || (op == OpRem);
   endfunction

   // Operand B is two's complement for these opcodes (MULHSU treats B as unsigned)
   function automatic logic op_b_signed(input logic [4:0] op);
      return (op == OpMul) || (op == OpMulh) || (op == OpDiv) || (op == OpRem);
   endfunction

endpackage

// File: rtl/alu_mc_muldiv_iter.sv
// Iterative multiply/divide core. Works on operand magnitudes: one shift-add or
// restoring-subtract step per cycle for WIDTH cycles, then applies the sign fix.
// The result is presented combinationally alongside o_done so the caller can register
// it on the same edge that retires the last iteration.
module alu_mc_muldiv_iter
   import alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [4:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_result
);

   localparam logic [SHAMT_W-1:0] LastIter = SHAMT_W'(WIDTH - 1);

   logic                 r_busy;
   logic [SHAMT_W-1:0]   r_cnt;
   logic [4:0]           r_op;
   logic                 r_is_div;
   logic                 r_neg_main;   // product / quotient must be negated
   logic                 r_neg_rem;    // remainder must be negated (follows sign of A)
   logic [2*WIDTH-1:0]   r_prod;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [WIDTH-1:0]     r_rem;
   logic [WIDTH-1:0]     r_quo;
   logic [WIDTH-1:0]     r_dvs;

   logic                 w_a_neg;
   logic                 w_b_neg;
   logic [WIDTH-1:0]     w_a_mag;
   logic [WIDTH-1:0]     w_b_mag;

   logic [2*WIDTH-1:0]   w_prod_d;
   logic [WIDTH:0]       w_shift;
   logic [WIDTH:0]       w_sub;
   logic                 w_ge;
   logic [WIDTH-1:0]     w_rem_d;
   logic [WIDTH-1:0]     w_quo_d;

   logic [2*WIDTH-1:0]   w_prod_fix;
   logic [WIDTH-1:0]     w_quo_fix;
   logic [WIDTH-1:0]     w_rem_fix;

   // Convert incoming operands to magnitudes according to opcode signedness
   always_comb begin
      w_a_neg = op_a_signed(i_op) && i_a[WIDTH-1];
      w_b_neg = op_b_signed(i_op) && i_b[WIDTH-1];
      w_a_mag = w_a_neg ? -i_a : i_a;
      w_b_mag = w_b_neg ? -i_b : i_b;
   end

   // One multiply step and one restoring-divide step, computed from the current state.
   // Since the remainder is always below the divisor, bit WIDTH of w_sub is a pure borrow.
   always_comb begin
      w_prod_d = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
      w_shift  = {r_rem, r_quo[WIDTH-1]};
      w_sub    = w_shift - {1'b0, r_dvs};
      w_ge     = ~w_sub[WIDTH];
      w_rem_d  = w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_quo_d  = {r_quo[WIDTH-2:0], w_ge};
   end

   // Sign fix and half/quotient/remainder selection on the post-step values
   always_comb begin
      w_prod_fix = r_neg_main ? -w_prod_d : w_prod_d;
      w_quo_fix  = r_neg_main ? -w_quo_d  : w_quo_d;
      w_rem_fix  = r_neg_rem  ? -w_rem_d  : w_rem_d;
      o_result   = '0;
      if (r_is_div) begin
         o_result = is_rem_op(r_op) ? w_rem_fix : w_quo_fix;
      end else if (r_op == OpMul) begin
         o_result = w_prod_fix[WIDTH-1:0];
      end else begin
         o_result = w_prod_fix[2*WIDTH-1:WIDTH];
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_busy && (r_cnt == LastIter);

   // Operand capture on start, then WIDTH iterations; reset aborts any run in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy     <= 1'b0;
         r_cnt      <= '0;
         r_op       <= '0;
         r_is_div   <= 1'b0;
         r_neg_main <= 1'b0;
         r_neg_rem  <= 1'b0;
         r_prod     <= '0;
         r_mcand    <= '0;
         r_mplier   <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvs      <= '0;
      end else if (i_start) begin
         r_busy     <= 1'b1;
         r_cnt      <= '0;
         r_op       <= i_op;
         r_is_div   <= is_div_op(i_op);
         r_neg_main <= w_a_neg ^ w_b_neg;
         r_neg_rem  <= w_a_neg;
         r_prod     <= '0;
         r_mcand    <= {{WIDTH{1'b0}}, w_a_mag};
         r_mplier   <= w_b_mag;
         r_rem      <= '0;
         r_quo      <= w_a_mag;
         r_dvs      <= w_b_mag;
      end else if (r_busy) begin
         r_prod   <= w_prod_d;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_rem    <= w_rem_d;
         r_quo    <= w_quo_d;
         if (r_cnt == LastIter) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
         end else begin
            r_cnt <= r_cnt + SHAMT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/M ALU. Base operations complete in one registered cycle with full
// throughput; M-extension operations run on the iterative core while the input side
// is stalled. Valid/ready handshakes on both sides; the output register holds under
// backpressure and may be refilled on the same edge it is drained.
module alu_mc
   import alu_mc_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data1_in,
   input  logic [WIDTH-1:0] data2_in,
   input  logic [4:0]       select_alu,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             zero
);

   localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] AllOnes = {WIDTH{1'b1}};

   alu_state_e         r_state;
   logic               r_out_valid;
   logic [WIDTH-1:0]   r_data;
   logic               r_zero;

   logic               w_accept;
   logic               w_start;
   logic               w_core_busy;
   logic               w_core_done;
   logic [WIDTH-1:0]   w_core_res;
   logic [SHAMT_W-1:0] w_shamt;
   logic [WIDTH-1:0]   w_base_res;
   logic               w_div_by_zero;
   logic               w_div_ovf;
   logic               w_div_special;
   logic [WIDTH-1:0]   w_special_res;
   logic [WIDTH-1:0]   w_imm_res;

   assign in_ready  = (r_state == StIdle) && !w_core_busy && (!r_out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign out_valid = r_out_valid;
   assign data_out  = r_data;
   assign zero      = r_zero;

   // Single-cycle base operation datapath
   always_comb begin
      w_shamt    = data2_in[SHAMT_W-1:0];
      w_base_res = '0;
      case (select_alu)
         OpAdd, OpAuipc: w_base_res = data1_in + data2_in;
         OpSub:          w_base_res = data1_in - data2_in;
         OpSll:          w_base_res = data1_in << w_shamt;
         OpSlt:          w_base_res = {{(WIDTH-1){1'b0}}, ($signed(data1_in) < $signed(data2_in))};
         OpSltu:         w_base_res = {{(WIDTH-1){1'b0}}, (data1_in < data2_in)};
         OpSrl:          w_base_res = data1_in >> w_shamt;
         OpSra:          w_base_res = $unsigned($signed(data1_in) >>> w_shamt);
         OpXor:          w_base_res = data1_in ^ data2_in;
         OpOr:           w_base_res = data1_in | data2_in;
         OpAnd:          w_base_res = data1_in & data2_in;
         OpLui:          w_base_res = data2_in;
         default:        w_base_res = '0;
      endcase
   end

   // Divide corner cases bypass the iterative core and complete like a base op
   always_comb begin
      w_div_by_zero = (data2_in == '0);
      w_div_ovf     = is_signed_div(select_alu) && (data1_in == MinNeg) && (data2_in == AllOnes);
      w_div_special = is_div_op(select_alu) && (w_div_by_zero || w_div_ovf);
      if (w_div_by_zero) begin
         w_special_res = is_rem_op(select_alu) ? data1_in : AllOnes;
      end else begin
         w_special_res = is_rem_op(select_alu) ? '0 : MinNeg;
      end
      w_imm_res = w_div_special ? w_special_res : w_base_res;
      w_start   = w_accept && is_m_op(select_alu) && !w_div_special;
   end

   alu_mc_muldiv_iter #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W)
   ) u_muldiv (
      .clk      (clk),
      .rst      (rst),
      .i_start  (w_start),
      .i_op     (select_alu),
      .i_a      (data1_in),
      .i_b      (data2_in),
      .o_busy   (w_core_busy),
      .o_done   (w_core_done),
      .o_result (w_core_res)
   );

   // Control FSM with the registered result; zero is always written together with data_out.
   // An M op is only accepted once the output register is drained, and nothing else can
   // load it while the core runs, so the completing result never overwrites a pending one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= StIdle;
         r_out_valid <= 1'b0;
         r_data      <= '0;
         r_zero      <= 1'b1;
      end else begin
         if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         case (r_state)
            StIdle: begin
               if (w_accept) begin
                  if (w_start) begin
                     r_state <= is_div_op(select_alu) ? StDiv : StMul;
                  end else begin
                     r_out_valid <= 1'b1;
                     r_data      <= w_imm_res;
                     r_zero      <= (w_imm_res == '0);
                  end
               end
            end
            StMul, StDiv: begin
               if (w_core_done) begin
                  r_out_valid <= 1'b1;
                  r_data      <= w_core_res;
                  r_zero      <= (w_core_res == '0);
                  r_state     <= StDone;
               end
            end
            StDone: begin
               r_state <= StIdle;
            end
            default: begin
               r_state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: scoreboard queue of expected results, one task per scenario.
module tb_alu_mc;

   localparam int unsigned WIDTH = 32;

   localparam logic [4:0] OP_ADD  = 5'h01;
   localparam logic [4:0] OP_SUB  = 5'h02;
   localparam logic [4:0] OP_SLT  = 5'h04;
   localparam logic [4:0] OP_SLTU = 5'h05;
   localparam logic [4:0] OP_SRL  = 5'h06;
   localparam logic [4:0] OP_SRA  = 5'h07;
   localparam logic [4:0] OP_LUI  = 5'h0B;
   localparam logic [4:0] OP_MUL  = 5'h10;
   localparam logic [4:0] OP_MULH = 5'h11;
   localparam logic [4:0] OP_MULHU = 5'h13;
   localparam logic [4:0] OP_DIV  = 5'h14;
   localparam logic [4:0] OP_DIVU = 5'h15;
   localparam logic [4:0] OP_REM  = 5'h16;
   localparam logic [4:0] OP_REMU = 5'h17;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] data1_in;
   logic [WIDTH-1:0] data2_in;
   logic [4:0]       select_alu;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic             zero;

   int checks;
   int errors;
   logic [WIDTH-1:0] exp_q[$];

   alu_mc #(
      .WIDTH   (WIDTH),
      .SHAMT_W (5)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data1_in   (data1_in),
      .data2_in   (data2_in),
      .select_alu (select_alu),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .data_out   (data_out),
      .zero       (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      in_valid   = 1'b1;
      select_alu = op;
      data1_in   = a;
      data2_in   = b;
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (in_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      select_alu = '0;
      data1_in = '0;
      data2_in = '0;
      repeat (3) step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (data_out !== 32'h0) begin
         errors++; $display("FAIL reset_data got %h want 00000000", data_out);
      end
      checks++;
      if (zero !== 1'b1) begin
         errors++; $display("FAIL reset_zero got %b want 1", zero);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] e;
      bit ok;
      wait_ready(ok);
      checks++;
      if (!ok) begin
         errors++; $display("FAIL b2b_ready got 0 want 1");
      end
      drive(OP_ADD, 32'h55555555, 32'hAAAAAAAA);
      exp_q.push_back(32'hFFFFFFFF);
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL add_valid got %b want 1", out_valid);
      end
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e) begin
         errors++; $display("FAIL add_data got %h want %h", data_out, e);
      end
      checks++;
      if (zero !== 1'b0) begin
         errors++; $display("FAIL add_zero got %b want 0", zero);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_no_bubble got %b want 1", in_ready);
      end
      drive(OP_SUB, 32'h12345678, 32'h12345678);
      exp_q.push_back(32'h00000000);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL sub_valid got %b want 1", out_valid);
      end
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e) begin
         errors++; $display("FAIL sub_data got %h want %h", data_out, e);
      end
      checks++;
      if (zero !== 1'b1) begin
         errors++; $display("FAIL sub_zero got %b want 1", zero);
      end
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL valid_clear got %b want 0", out_valid);
      end
   endtask

   task automatic test_base_ops();
      logic [4:0]       ops[5];
      logic [WIDTH-1:0] av[5];
      logic [WIDTH-1:0] bv[5];
      logic [WIDTH-1:0] ev[5];
      logic [WIDTH-1:0] e;
      bit ok;
      ops = '{OP_SRA, OP_SRL, OP_SLT, OP_SLTU, OP_LUI};
      av  = '{32'h83800155, 32'h83800155, 32'd4, 32'hFFFFFFFF, 32'h00000000};
      bv  = '{32'd4, 32'd4, 32'h03800155, 32'd1, 32'hABCDE000};
      ev  = '{32'hF8380015, 32'h08380015, 32'd1, 32'd0, 32'hABCDE000};
      wait_ready(ok);
      for (int i = 0; i < 5; i++) begin
         drive(ops[i], av[i], bv[i]);
         exp_q.push_back(ev[i]);
         step();
         checks++;
         if (out_valid !== 1'b1) begin
            errors++; $display("FAIL base_valid[%0d] got %b want 1", i, out_valid);
         end
         e = exp_q.pop_front();
         checks++;
         if (data_out !== e) begin
            errors++; $display("FAIL base_data[%0d] got %h want %h", i, data_out, e);
         end
         checks++;
         if (zero !== (e == '0)) begin
            errors++; $display("FAIL base_zero[%0d] got %b want %b", i, zero, (e == '0));
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_mul();
      logic [4:0]       ops[3];
      logic [WIDTH-1:0] ev[3];
      logic [WIDTH-1:0] e;
      int lat;
      bit saw_ready;
      bit ok;
      ops = '{OP_MUL, OP_MULH, OP_MULHU};
      ev  = '{32'hFFFFFFFA, 32'hFFFFFFFF, 32'h00000002};
      for (int i = 0; i < 3; i++) begin
         wait_ready(ok);
         checks++;
         if (!ok) begin
            errors++; $display("FAIL mul_ready[%0d] got 0 want 1", i);
         end
         drive(ops[i], 32'hFFFFFFFE, 32'd3);
         exp_q.push_back(ev[i]);
         step();
         // operand changes after acceptance must not leak into the result
         in_valid = 1'b0;
         data1_in = 32'hDEADBEEF;
         data2_in = 32'h00000000;
         select_alu = OP_ADD;
         lat = 1;
         saw_ready = 1'b0;
         while (out_valid !== 1'b1 && lat < 100) begin
            if (in_ready === 1'b1) saw_ready = 1'b1;
            step();
            lat++;
         end
         checks++;
         if (lat != 33) begin
            errors++; $display("FAIL mul_latency[%0d] got %0d want 33", i, lat);
         end
         checks++;
         if (saw_ready) begin
            errors++; $display("FAIL mul_in_ready[%0d] got 1 want 0", i);
         end
         e = exp_q.pop_front();
         checks++;
         if (data_out !== e) begin
            errors++; $display("FAIL mul_data[%0d] got %h want %h", i, data_out, e);
         end
      end
      step();
   endtask

   task automatic test_div();
      logic [4:0]       ops[4];
      logic [WIDTH-1:0] av[4];
      logic [WIDTH-1:0] bv[4];
      logic [WIDTH-1:0] ev[4];
      logic [WIDTH-1:0] e;
      int lat;
      bit ok;
      ops = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU};
      av  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
      bv  = '{32'd2, 32'd2, 32'd7, 32'd7};
      ev  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
      for (int i = 0; i < 4; i++) begin
         wait_ready(ok);
         drive(ops[i], av[i], bv[i]);
         exp_q.push_back(ev[i]);
         step();
         in_valid = 1'b0;
         data1_in = 32'h0;
         data2_in = 32'h0;
         lat = 1;
         while (out_valid !== 1'b1 && lat < 100) begin
            step();
            lat++;
         end
         checks++;
         if (lat != 33) begin
            errors++; $display("FAIL div_latency[%0d] got %0d want 33", i, lat);
         end
         e = exp_q.pop_front();
         checks++;
         if (data_out !== e) begin
            errors++; $display("FAIL div_data[%0d] got %h want %h", i, data_out, e);
         end
         checks++;
         if (zero !== (e == '0)) begin
            errors++; $display("FAIL div_zero[%0d] got %b want %b", i, zero, (e == '0));
         end
      end
      step();
   endtask

   task automatic test_div_special();
      logic [4:0]       ops[4];
      logic [WIDTH-1:0] av[4];
      logic [WIDTH-1:0] bv[4];
      logic [WIDTH-1:0] ev[4];
      logic [WIDTH-1:0] e;
      bit ok;
      ops = '{OP_DIV, OP_REM, OP_DIV, OP_REM};
      av  = '{32'd7, 32'd7, 32'h80000000, 32'h80000000};
      bv  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
      ev  = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0};
      wait_ready(ok);
      for (int i = 0; i < 4; i++) begin
         drive(ops[i], av[i], bv[i]);
         exp_q.push_back(ev[i]);
         step();
         checks++;
         if (out_valid !== 1'b1) begin
            errors++; $display("FAIL special_valid[%0d] got %b want 1", i, out_valid);
         end
         e = exp_q.pop_front();
         checks++;
         if (data_out !== e) begin
            errors++; $display("FAIL special_data[%0d] got %h want %h", i, data_out, e);
         end
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL special_in_ready[%0d] got %b want 1", i, in_ready);
         end
      end
      in_valid = 1'b0;
      step();
   endtask

   task automatic test_backpressure();
      logic [WIDTH-1:0] e;
      bit ok;
      wait_ready(ok);
      drive(OP_ADD, 32'd3, 32'd4);
      exp_q.push_back(32'd7);
      step();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL bp_valid got %b want 1", out_valid);
      end
      // a competing request must be refused while the result is held
      drive(OP_SUB, 32'd9, 32'd1);
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || data_out !== exp_q[0]) begin
            errors++;
            $display("FAIL bp_hold[%0d] got valid=%b data=%h want valid=1 data=%h",
                     i, out_valid, data_out, exp_q[0]);
         end
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready);
         end
      end
      in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e) begin
         errors++; $display("FAIL bp_data got %h want %h", data_out, e);
      end
      out_ready = 1'b1;
      step();
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain got %b want 0", out_valid);
      end
   endtask

   task automatic test_reset_abort();
      logic [WIDTH-1:0] e;
      bit ok;
      bit seen;
      wait_ready(ok);
      // result of this DIVU is discarded by the reset, so nothing is queued
      drive(OP_DIVU, 32'd100, 32'd7);
      step();
      in_valid = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL abort_valid got %b want 0", out_valid);
      end
      checks++;
      if (data_out !== 32'h0) begin
         errors++; $display("FAIL abort_data got %h want 00000000", data_out);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++; $display("FAIL abort_in_ready got %b want 1", in_ready);
      end
      seen = 1'b0;
      repeat (40) begin
         step();
         if (out_valid === 1'b1) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++; $display("FAIL abort_stale_result got 1 want 0");
      end
      drive(OP_ADD, 32'd1, 32'd1);
      exp_q.push_back(32'd2);
      step();
      in_valid = 1'b0;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL post_reset_valid got %b want 1", out_valid);
      end
      e = exp_q.pop_front();
      checks++;
      if (data_out !== e) begin
         errors++; $display("FAIL post_reset_data got %h want %h", data_out, e);
      end
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_back_to_back();
      test_base_ops();
      test_mul();
      test_div();
      test_div_special();
      test_backpressure();
      test_reset_abort();
      checks++;
      if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_empty got %0d want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the combinational RV32I ALU.
- Executes the base ALU operation set in one registered cycle.
- Adds the RISC-V M-extension operations (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) using an iterative shift-add/restoring datapath.
- Sits between the execute-stage operand muxes and writeback, with valid/ready handshakes on both sides so the pipeline can stall on long operations.

Parameters:
- WIDTH, 32, datapath width. Must be a power of two and at least 8.
- SHAMT_W, $clog2(WIDTH), number of low data2_in bits used as the shift amount.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  an operation is presented on the data/select inputs.
- in_ready  out  1  the block accepts the operation this cycle.
- data1_in  in  WIDTH  operand A (rs1 or PC).
- data2_in  in  WIDTH  operand B (rs2 or immediate).
- select_alu  in  5  operation code; see Behaviour.
- out_valid  out  1  data_out and zero hold a result.
- out_ready  in  1  the consumer takes the result this cycle.
- data_out  out  WIDTH  result.
- zero  out  1  high when data_out == 0.

Behaviour:
- Operation codes, base set (bit 4 = 0):
  - ADD 0x01, SUB 0x02, SLL 0x03, SLT 0x04, SLTU 0x05, SRL 0x06, SRA 0x07.
  - XOR 0x08, OR 0x09, AND 0x0A.
  - LUI 0x0B: result = data2_in.
  - AUIPC 0x0C: result = data1_in + data2_in.
- Operation codes, M set: MUL 0x10, MULH 0x11, MULHSU 0x12, MULHU 0x13, DIV 0x14, DIVU 0x15, REM 0x16, REMU 0x17.
- Any other code produces result 0 with base-op latency.
- Arithmetic rules:
  - Add/sub wrap modulo 2^WIDTH.
  - Shifts use data2_in[SHAMT_W-1:0].
  - SLT/SLTU return 0 or 1, zero-extended.
- Reset (rst=1 at a clock edge):
  - state=IDLE, out_valid=0, data_out=0, zero=1, iteration counter=0.
  - An in-flight M operation is aborted and its result is discarded.
  - in_ready=1 in the first cycle after reset is released.
- in_ready = (state==IDLE) && (!out_valid || out_ready). The result register can therefore be refilled in the same cycle it is drained.
- Accept: an operation is accepted on a cycle where in_valid && in_ready. Operands and opcode are captured on that edge; input changes after acceptance are ignored.
- FSM states: IDLE, MUL, DIV, DONE.
- IDLE + base op accepted at edge N: the result is registered at N, so out_valid=1 in cycle N+1. State stays IDLE, giving back-to-back throughput of 1 per cycle.
- IDLE + MUL-class op accepted: go to MUL.
  - Operands are converted to magnitudes per the signedness of the opcode (MULHSU: A signed, B unsigned).
  - WIDTH shift-add iterations run, one per cycle, into a 2*WIDTH product.
  - Go to DONE, apply the sign fix, load data_out, set out_valid.
  - Result first visible in cycle N+WIDTH+1; MUL returns the low half, the others the high half.
- IDLE + DIV-class op accepted: go to DIV and run WIDTH restoring iterations on magnitudes, then DONE. Same latency as MUL.
  - Quotient sign = sign(A) XOR sign(B); remainder sign = sign(A).
- DIV-class special cases, resolved at acceptance with base-op latency (1 cycle, no iteration):
  - Divide by zero: DIV/DIVU = all ones; REM/REMU = data1_in.
  - Signed overflow (A = most-negative, B = -1): DIV = most-negative, REM = 0.
- DONE lasts one cycle and returns to IDLE. If the previous result is still unconsumed, completion waits in DONE until out_ready, so a result is never overwritten while out_valid && !out_ready.
- Output holding: while out_valid && !out_ready, data_out and zero hold stable.
- Output clear: out_valid clears after a handshake unless a new result is written in the same cycle.
- zero is registered together with data_out and always equals (data_out==0).
- The counter counts 0..WIDTH-1 and wraps to 0 on the exit from MUL/DIV.

Decomposition:
- alu_pkg:
  - opcode localparams (5-bit).
  - FSM state encoding.
  - helper function for the M-class and divide-class opcode decode.
- One sub-module, muldiv_iter:
  - the iterative multiplier/divider core with start/busy/done signals and operand sign handling.
  - alu_mc holds the handshake, the base-op datapath and the output register.

Test Plan:
- ADD 0x55555555 + 0xAAAAAAAA (in_valid held 1 cycle, out_ready=1) -> out_valid in next cycle, data_out=0xFFFFFFFF, zero=0. Then SUB 0x12345678 - 0x12345678 -> 0x00000000, zero=1. Both issued back-to-back with no bubble.
- SRA 0x83800155 by 4 -> 0xF8380015. SRL same operands -> 0x08380015. SLT 4 vs 0x03800155 -> 1. SLTU 0xFFFFFFFF vs 1 -> 0. LUI data2=0xABCDE000 -> 0xABCDE000.
- MUL/MULH/MULHU on A=0xFFFFFFFE, B=3:
  - MUL -> 0xFFFFFFFA.
  - MULH -> 0xFFFFFFFF.
  - MULHU -> 0x00000002.
  - Each: out_valid exactly 33 cycles after accept, and in_ready=0 throughout.
- Signed divide A=0xFFFFFFF9 (-7), B=2: DIV -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special divides, each with 1-cycle latency:
  - DIV 7/0 -> 0xFFFFFFFF.
  - REM 7/0 -> 7.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Backpressure and reset:
  - With out_ready=0 after a result, data_out stays stable for 5 cycles and in_ready stays 0.
  - rst asserted in cycle 10 of a DIVU -> next cycle out_valid=0, data_out=0, in_ready=1.
  - A new ADD 1+1 then returns 2.
